// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: bubble word, reset vector default and the
// fetch-to-decode pipeline register bundle.
package fetch_stage_pkg;
  localparam logic [31:0] NOP_INST_WORD     = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0000_0000;
  localparam int          ID_INST_W         = 32;
  localparam int          ID_PC_W           = 32;
  localparam int          ID_ENTRY_W        = ID_INST_W + ID_PC_W;

  typedef struct packed {
    logic [ID_INST_W-1:0] inst;
    logic [ID_PC_W-1:0]   pc;
  } id_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_inst_fifo.sv
// Small power-of-two instruction buffer with push/pop/flush and occupancy count.
module inst_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ID_ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: in-order imem requests, response buffering, stall hold and
// redirect flush with discard of stale in-flight responses.
//   state    | meaning
//   ST_RUN   | drop == 0, responses are buffered
//   ST_FLUSH | drop != 0, responses are stale and discarded
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT,
  parameter int          FIFO_DEPTH   = 2,
  parameter logic [31:0] NOP_INST     = NOP_INST_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_reg_pc
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] pending, pending_nxt, drop, drop_nxt, fifo_count;
  logic [CW:0]   inflight;
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [AW-1:0] pcq_wr, pcq_rd;
  fetch_state_t  state, state_nxt;
  logic          fire, discard, accept, pop_en, bypass;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  id_entry_t     resp_entry, head, out_entry;

  assign inflight       = {1'b0, pending} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n & ~redirect_valid & (inflight < DEPTH_L);
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid & imem_req_ready;

  // The request PC travels in its own queue so the response path needs no adder.
  assign resp_entry = '{inst: imem_resp_inst, pc: pcq[pcq_rd]};
  assign discard    = redirect_valid | (state == ST_FLUSH);
  assign accept     = imem_resp_valid & ~discard;
  assign pop_en     = ~redirect_valid & ~stall & (~fifo_empty | accept);
  assign bypass     = pop_en & fifo_empty;
  assign fifo_push  = accept & ~bypass & ~fifo_full;
  assign fifo_pop   = pop_en & ~fifo_empty;
  assign out_entry  = fifo_empty ? resp_entry : head;

  assign pending_nxt = pending + CW'(fire) - CW'(imem_resp_valid);

  always_comb begin
    drop_nxt = drop;
    if (redirect_valid)
      drop_nxt = pending_nxt;
    else if (state == ST_FLUSH && imem_resp_valid)
      drop_nxt = drop - CW'(1);
    state_nxt = (drop_nxt != '0) ? ST_FLUSH : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      drop    <= '0;
      pending <= '0;
      pc      <= RESET_VECTOR;
      pcq_wr  <= '0;
      pcq_rd  <= '0;
    end else begin
      state   <= state_nxt;
      drop    <= drop_nxt;
      pending <= pending_nxt;
      if (redirect_valid) pc <= redirect_pc & ~32'h3;
      else if (fire)      pc <= pc + 32'd4;
      if (fire)            pcq_wr <= pcq_wr + AW'(1);
      if (imem_resp_valid) pcq_rd <= pcq_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fire) pcq[pcq_wr] <= pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid  <= 1'b0;
      id_inst   <= NOP_INST;
      id_reg_pc <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end else if (stall) begin
      id_valid <= id_valid;
    end else if (pop_en) begin
      id_valid  <= 1'b1;
      id_inst   <= out_entry.inst;
      id_reg_pc <= out_entry.pc;
    end else begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end
  end

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_ENTRY_W)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (resp_entry),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory model and a
// transaction-level scoreboard of the expected decode and request streams.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_inst, id_reg_pc;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .id_valid        (id_valid),
    .id_inst         (id_inst),
    .id_reg_pc       (id_reg_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0 || a == 32'h4) return 32'h0050_0093;
    return a | 32'h3;
  endfunction

  // In-order instruction memory, latency mem_lat cycles, reset by rst_n.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    cyc     = 0;
  int    mem_lat = 1;

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_inst  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_inst  = word(mq[0].addr);
        mq.delete(0);
      end else begin
        imem_resp_valid = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        imem_resp_valid = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      end
    end
  end

  // Scoreboard: expected PC streams, outstanding requests tagged by redirect
  // epoch, and kept/consumed counts giving the buffered instruction total.
  logic [31:0] exp_pc, exp_req_pc, prev_inst, prev_reg_pc;
  logic        prev_valid;
  bit          prev_rst_low = 1'b1, prev_stall = 1'b0, prev_redir = 1'b0, exp_pop = 1'b0;
  int          pending_m = 0, kept = 0, pops = 0, epoch = 0, buffered, ep;
  int          epq[$];
  bit          exp_req_valid;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        pending_m = 0; kept = 0; pops = 0; epq.delete();
        exp_pc = RV; exp_req_pc = RV;
        prev_rst_low = 1'b1; prev_stall = 1'b0; prev_redir = 1'b0; exp_pop = 1'b0;
      end else begin
        if (prev_rst_low) begin
          check("rst_id_valid", {31'b0, id_valid}, 32'd0);
          check("rst_id_inst", id_inst, NOP);
          check("rst_id_pc", id_reg_pc, 32'd0);
        end else if (prev_redir) begin
          check("redir_id_valid", {31'b0, id_valid}, 32'd0);
          check("redir_id_inst", id_inst, NOP);
          check("redir_id_pc_hold", id_reg_pc, prev_reg_pc);
        end else if (prev_stall) begin
          check("stall_hold_valid", {31'b0, id_valid}, {31'b0, prev_valid});
          check("stall_hold_inst", id_inst, prev_inst);
          check("stall_hold_pc", id_reg_pc, prev_reg_pc);
        end else if (exp_pop) begin
          check("id_valid", {31'b0, id_valid}, 32'd1);
          check("id_pc", id_reg_pc, exp_pc);
          check("id_inst", id_inst, word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          pops++;
        end else begin
          check("bubble_valid", {31'b0, id_valid}, 32'd0);
          check("bubble_inst", id_inst, NOP);
          check("bubble_pc_hold", id_reg_pc, prev_reg_pc);
        end

        buffered      = kept - pops;
        exp_req_valid = !redirect_valid && (pending_m + buffered < DEPTH);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_valid});
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);

        if (imem_resp_valid) begin
          check("resp_has_pending", {31'b0, pending_m > 0}, 32'd1);
          if (pending_m > 0) begin
            ep = epq.pop_front();
            if (ep == epoch && !redirect_valid) kept++;
            pending_m--;
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          epq.push_back(epoch);
          pending_m++;
          exp_req_pc = exp_req_pc + 32'd4;
        end
        if (redirect_valid) begin
          epoch++;
          kept = 0;
          pops = 0;
          exp_pc     = redirect_pc & ~32'h3;
          exp_req_pc = redirect_pc & ~32'h3;
        end
        exp_pop      = !redirect_valid && !stall && (kept - pops > 0);
        prev_rst_low = 1'b0;
        prev_stall   = stall;
        prev_redir   = redirect_valid;
      end
      prev_valid  = id_valid;
      prev_inst   = id_inst;
      prev_reg_pc = id_reg_pc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] p_pc, p_inst, a0;
  bit          found;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; mem_lat = 1;

    // Reset release and steady streaming
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_first_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("t1_id_valid", {31'b0, id_valid}, 32'd1);
    check("t1_id_inst", id_inst, 32'h0050_0093);
    check("t1_id_pc", id_reg_pc, 32'h0);
    @(negedge clk);
    check("t1_pc4", id_reg_pc, 32'h4);
    check("t1_pc4_inst", id_inst, 32'h0050_0093);
    @(negedge clk);
    check("t1_pc8", id_reg_pc, 32'h8);
    check("t1_pc8_inst", id_inst, 32'h0000_000B);

    // Stall for three cycles
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk); p_pc = id_reg_pc; p_inst = id_inst;
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_hold1_pc", id_reg_pc, p_pc);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_hold2_pc", id_reg_pc, p_pc);
    check("t2_hold2_inst", id_inst, p_inst);
    check("t2_req_stopped", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1 stall = 1'b0;
    repeat (6) @(negedge clk);

    // Redirect with two requests outstanding
    @(posedge clk); #1 mem_lat = 3;
    repeat (8) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_bubble", {31'b0, id_valid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (id_valid) found = 1'b1;
    end
    check("t3_found", {31'b0, found}, 32'd1);
    check("t3_first_pc", id_reg_pc, 32'h0000_0100);
    check("t3_first_inst", id_inst, 32'h0000_0103);

    // Redirect coincident with a response and stall
    @(posedge clk); #1 mem_lat = 1;
    repeat (6) @(posedge clk);
    #1 stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_valid", {31'b0, id_valid}, 32'd0);
    check("t4_inst", id_inst, NOP);
    @(posedge clk); #1 stall = 1'b0;

    // Memory not ready for five cycles
    repeat (4) @(posedge clk);
    #1 imem_req_ready = 1'b0;
    @(negedge clk); a0 = imem_req_addr;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("t5_addr_stable", imem_req_addr, a0);
    end
    check("t5_id_bubble", {31'b0, id_valid}, 32'd0);
    @(posedge clk); #1 imem_req_ready = 1'b1;

    // PC wrap at the top of the address space, then mid-stream reset
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1 redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (id_valid && id_reg_pc == 32'hFFFF_FFFC) found = 1'b1;
    end
    check("t6_found_top", {31'b0, found}, 32'd1);
    check("t6_top_inst", id_inst, 32'hFFFF_FFFF);
    @(negedge clk);
    check("t6_wrap_valid", {31'b0, id_valid}, 32'd1);
    check("t6_wrap_pc", id_reg_pc, 32'h0);
    check("t6_wrap_inst", id_inst, 32'h0050_0093);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("t6_rst_id_inst", id_inst, NOP);
    check("t6_rst_id_pc", id_reg_pc, 32'h0);
    check("t6_restart_addr", imem_req_addr, RV);
    check("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t6_restart_id_valid", {31'b0, id_valid}, 32'd1);
    check("t6_restart_id_pc", id_reg_pc, RV);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the 5-stage RV32I pipeline. Produces the instruction word and PC that the decode stage captures every clock.
- Issues in-order word requests to instruction memory over a valid/ready request channel. Responses return in order on a valid-only channel.
- Buffers responses in a small FIFO. Honours stall from downstream and PC redirects from execute (branch/jump/trap), discarding any stale in-flight fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.
- FIFO_DEPTH, 2, number of instruction buffer entries. Also caps outstanding plus buffered fetches. Legal values: 2, 4, 8.
- NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0) driven to decode when no valid instruction is present.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous reset, active low, sampled on posedge clk.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  instruction word returned this cycle.
- imem_resp_inst  in  32  returned instruction word.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored and treated as 0.
- stall  in  1  decode cannot accept; hold outputs.
- id_valid  out  1  id_inst/id_reg_pc hold a real instruction.
- id_inst  out  32  instruction to decode (inst).
- id_reg_pc  out  32  PC of id_inst (reg_pc).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: pc=RESET_VECTOR, pending=0, drop=0, FIFO empty, id_valid=0, id_inst=NOP_INST, id_reg_pc=0. imem_req_valid is 0 while rst_n=0.
- Counters:
  - pending: accepted requests not yet responded, 0..FIFO_DEPTH.
  - drop: responses still to be discarded, 0..pending.
  - count: FIFO occupancy.
- FIFO entry: {inst[31:0], pc[31:0]}. The pc is captured into a parallel PC queue at request acceptance, so no pc arithmetic is done on the response path.
- Request channel:
  - imem_req_valid = rst_n & !redirect_valid & (pending + count < FIFO_DEPTH). This is combinational from registered state.
  - imem_req_addr = pc.
  - Fire = valid & ready. On fire: pc += 4 (wraps modulo 2^32), pending += 1.
  - valid and addr are stable until fire unless a redirect occurs.
- Response channel:
  - Every response decrements pending. Minimum latency is 1 cycle after fire.
  - If drop != 0: discard the response and decrement drop.
  - Otherwise push {imem_resp_inst, queued pc} into the FIFO.
  - A response never arrives with pending=0. The verification bench asserts this.
- States: RUN (drop==0) and FLUSH (drop!=0).
  - FLUSH discards responses only. New requests at the redirected pc may issue in FLUSH, within capacity.
  - FLUSH returns to RUN when drop reaches 0.
- Output register, updated every cycle; priority top-down:
  1. redirect_valid: id_valid<=0, id_inst<=NOP_INST, id_reg_pc unchanged. Ignores stall.
  2. stall: all id_* hold; FIFO not popped.
  3. FIFO non-empty, or a response is being pushed into an empty FIFO (bypass allowed): pop head; id_valid<=1, id_inst/id_reg_pc<=entry.
  4. Otherwise: id_valid<=0, id_inst<=NOP_INST, id_reg_pc unchanged.
- Redirect cycle:
  - FIFO cleared.
  - pc<=redirect_pc&~3.
  - drop<=pending after this cycle's response is accounted.
  - A response arriving in the redirect cycle is discarded.
  - No request issues in the redirect cycle.
- Back-to-back redirects: each recomputes drop from the current pending. The last redirect wins.
- Full: with pending+count==FIFO_DEPTH, requests stop. A simultaneous pop does not re-enable request in the same cycle; the condition uses registered counts.
- Steady-state throughput: one instruction per cycle with 1-cycle memory latency and FIFO_DEPTH>=2.
- Reset mid-operation: all state returns to reset values. Responses for pre-reset requests are not expected; the memory is reset by the same rst_n.

Decomposition:
- Shared package: NOP_INST, RESET_VECTOR default, and the id-bundle field widths. The pipeline-register bundle widths are reused by the decode stage.
- Sub-module inst_fifo (parameterised depth, 64-bit entry, push/pop/flush, count, empty/full). It is instantiated once and is also reusable in other stages.

Test Plan:
1. Reset release, memory ready=1, latency 1, returning 32'h00500093 at 0x0 then 0x4 → first request addr=0x0 on the first cycle after release; id_valid=1, id_inst=32'h00500093, id_reg_pc=0 three cycles after release; one instruction per cycle after that.
2. stall held 3 cycles with FIFO_DEPTH=2 → id_* frozen; requests stop once pending+count=2; no instruction lost or duplicated after stall drops.
3. redirect_valid with pending=2, redirect_pc=0x100 → next id_valid=0; both old responses discarded; first valid id_reg_pc=0x100.
4. redirect coincident with a response and with stall=1 → response dropped; id_inst=NOP_INST, id_valid=0 despite stall.
5. imem_req_ready=0 for 5 cycles → imem_req_valid high with addr stable; pc unchanged; id outputs bubble.
6. pc=0xFFFF_FFFC fetch → next request addr wraps to 0x0000_0000; rst_n=0 mid-stream for 1 cycle → all outputs at reset values and fetch restarts at RESET_VECTOR.
